player_ctl: RTL and testbench
=============================

// Module: player_ctl
// PURPOSE
//  Source of the 20-bit sprite position word consumed by the player sprite draw stage: {y[9:0], x[9:0]}.
//  x and y are playfield-relative and give the top-left of the 64x64 sprite.
//  Updates the position once per frame, on the rising edge of vblnk, from left/right/jump controls.
//  Horizontal moves clamp to the playfield. A GROUND/RISE/FALL state machine with gravity handles jumps.
//  Sits between the input decoder (keyboard/buttons) and player_draw in the timing-signal chain.
// PARAMETERS
//  X_INIT   224  x after reset
//  X_MAX    512  largest legal x (field width 576 - sprite 64)
//  STEP_X   4    horizontal pixels per frame
//  GROUND_Y 640  y when standing; also largest legal y
//  JUMP_V0  20   initial upward speed, px/frame (8 bit)
//  GRAVITY  1    speed change per frame (8 bit, >0)
//  V_MAX    20   terminal fall speed (8 bit)
// PORTS
//  i_pclk     in   1   pixel clock; the only clock
//  i_rst      in   1   synchronous reset, active-high
//  i_vblnk    in   1   vertical blank from timing chain; frame tick source
//  i_left     in   1   move-left level, synchronous to i_pclk
//  i_right    in   1   move-right level, synchronous to i_pclk
//  i_jump     in   1   jump level, synchronous to i_pclk
//  o_data     out  20  {y[9:0], x[9:0]}, registered
//  o_airborne out  1   1 while state is RISE or FALL, registered
// BEHAVIOUR
//  - Frame tick: vblnk_q <= i_vblnk; tick = i_vblnk & ~vblnk_q.
//    All state, x, y, vel and the outputs update only on the clock edge where tick=1.
//    New o_data is visible the cycle after the vblnk rising-edge cycle. It is stable for the whole active frame.
//  - Controls are sampled only on the tick cycle. Between ticks they are ignored.
//  - Reset (any time, including mid-jump):
//    x=X_INIT, y=GROUND_Y, vel=0, state=GROUND, armed=1, vblnk_q=0.
//    o_data={GROUND_Y,X_INIT}, o_airborne=0.
//  - Horizontal, evaluated every tick in every state:
//    left&~right: x = (x<STEP_X) ? 0 : x-STEP_X.
//    right&~left: x = (x+STEP_X>X_MAX) ? X_MAX : x+STEP_X. Compute in 11 bits.
//    Both or neither pressed: x holds.
//  - Arm: at a tick with i_jump=0, armed<=1. A jump needs armed=1, so holding jump does not auto-repeat.
//  - FSM transitions (vel is an unsigned 8-bit magnitude; direction is implied by state):
//    GROUND: jump&armed -> RISE, vel=JUMP_V0, armed=0, y unchanged this tick. Otherwise y=GROUND_Y.
//    RISE, vel>=y: y=0, vel=0 -> FALL (ceiling clamp).
//    RISE, vel>GRAVITY: y-=vel, vel-=GRAVITY.
//    RISE, otherwise: y-=vel, vel=0 -> FALL.
//    FALL: vn=min(vel+GRAVITY,V_MAX). Compute in 9 bits.
//      If y+vn>=GROUND_Y: y=GROUND_Y, vel=0 -> GROUND. Compute in 11 bits.
//      Otherwise y+=vn, vel=vn.
//  - i_jump in RISE/FALL is ignored apart from re-arming.
//    Landing and a jump request on the same tick: land only. A jump is possible at the next tick.
//  - o_airborne reflects the state after the tick update.
//  - No combinational path from inputs to outputs.
// TESTING
//  1. Reset, then 3 ticks -> o_data={640,224}, o_airborne=0 throughout.
//  2. i_right=1 for 80 ticks from x=224 -> x=512 after tick 72, holds 512.
//     Then i_left=1 -> 508; both pressed -> x holds.
//  3. i_left=1 from x=2 (X_INIT=2 override) -> x=0 after one tick, stays 0.
//  4. i_jump pulse from GROUND at tick 0 -> o_airborne=1.
//     y=620 after tick 1. Apex y=430, FALL, after tick 20.
//     y=640, o_airborne=0, after tick 40.
//  5. i_jump held through a full jump -> no second jump after landing.
//     Release for one tick, press again -> new jump starts.
//  6. Assert i_rst at tick 10 of a jump -> next cycle o_data={640,224}, o_airborne=0.
//     Also: i_vblnk held high for many cycles -> exactly one update.

Source files
------------

// File: rtl/player_ctl.sv
// Player sprite position controller: one position update per frame at the vblnk rising edge.
// Handles clamped horizontal moves and a GROUND/RISE/FALL jump with gravity.
module player_ctl #(
    parameter int X_INIT   = 224,
    parameter int X_MAX    = 512,
    parameter int STEP_X   = 4,
    parameter int GROUND_Y = 640,
    parameter int JUMP_V0  = 20,
    parameter int GRAVITY  = 1,
    parameter int V_MAX    = 20
) (
    input  logic        i_pclk,
    input  logic        i_rst,
    input  logic        i_vblnk,
    input  logic        i_left,
    input  logic        i_right,
    input  logic        i_jump,
    output logic [19:0] o_data,
    output logic        o_airborne,
    output logic [1:0]  o_state
);

    localparam logic [9:0]  X_INIT_C = 10'(X_INIT);
    localparam logic [9:0]  X_MAX_C  = 10'(X_MAX);
    localparam logic [9:0]  STEP_C   = 10'(STEP_X);
    localparam logic [9:0]  GROUND_C = 10'(GROUND_Y);
    localparam logic [7:0]  JV0_C    = 8'(JUMP_V0);
    localparam logic [7:0]  GRAV_C   = 8'(GRAVITY);
    localparam logic [7:0]  VMAX_C   = 8'(V_MAX);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [7:0]  vel_q, vel_d;
    logic        armed_q, armed_d;
    logic        vblnk_q;
    logic        tick;

    logic [10:0] x_add;
    logic [8:0]  vn9;
    logic [7:0]  vn;
    logic [10:0] y_fall;

    assign tick = i_vblnk & ~vblnk_q;

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            vblnk_q <= 1'b0;
            state_q <= ST_GROUND;
            x_q     <= X_INIT_C;
            y_q     <= GROUND_C;
            vel_q   <= 8'd0;
            armed_q <= 1'b1;
        end else begin
            vblnk_q <= i_vblnk;
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vel_d   = vel_q;
        armed_d = armed_q;
        x_add   = {1'b0, x_q} + {1'b0, STEP_C};
        vn9     = {1'b0, vel_q} + {1'b0, GRAV_C};
        vn      = (vn9 > {1'b0, VMAX_C}) ? VMAX_C : vn9[7:0];
        y_fall  = {1'b0, y_q} + {3'b000, vn};

        if (tick) begin
            if (i_left && !i_right) begin
                x_d = (x_q < STEP_C) ? 10'd0 : x_q - STEP_C;
            end else if (i_right && !i_left) begin
                x_d = (x_add > {1'b0, X_MAX_C}) ? X_MAX_C : x_add[9:0];
            end

            if (!i_jump) begin
                armed_d = 1'b1;
            end

            // vel is a magnitude; the state says whether it moves y up or down.
            unique case (state_q)
                ST_GROUND: begin
                    if (i_jump && armed_q) begin
                        state_d = ST_RISE;
                        vel_d   = JV0_C;
                        armed_d = 1'b0;
                    end else begin
                        y_d = GROUND_C;
                    end
                end
                ST_RISE: begin
                    if ({2'b00, vel_q} >= y_q) begin
                        y_d     = 10'd0;
                        vel_d   = 8'd0;
                        state_d = ST_FALL;
                    end else if (vel_q > GRAV_C) begin
                        y_d   = y_q - {2'b00, vel_q};
                        vel_d = vel_q - GRAV_C;
                    end else begin
                        y_d     = y_q - {2'b00, vel_q};
                        vel_d   = 8'd0;
                        state_d = ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (y_fall >= {1'b0, GROUND_C}) begin
                        y_d     = GROUND_C;
                        vel_d   = 8'd0;
                        state_d = ST_GROUND;
                    end else begin
                        y_d   = y_fall[9:0];
                        vel_d = vn;
                    end
                end
                default: begin
                    state_d = ST_GROUND;
                end
            endcase
        end
    end

    assign o_data     = {y_q, x_q};
    assign o_airborne = (state_q != ST_GROUND);
    assign o_state    = state_q;

endmodule

// File: tb/tb_player_ctl.sv
// Scoreboard bench for player_ctl: the driver queues hand-computed positions per frame,
// a monitor pops and compares them the cycle after each vblnk rising edge.
module tb_player_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic vblnk = 1'b0;
    logic left  = 1'b0;
    logic right = 1'b0;
    logic jump  = 1'b0;
    logic left2 = 1'b0;
    logic zero  = 1'b0;

    logic [19:0] data1, data2;
    logic        air1, air2;
    logic [1:0]  st1, st2;

    player_ctl dut (
        .i_pclk(clk), .i_rst(rst), .i_vblnk(vblnk),
        .i_left(left), .i_right(right), .i_jump(jump),
        .o_data(data1), .o_airborne(air1), .o_state(st1)
    );

    // Second instance starts near the left wall to exercise the lower clamp.
    player_ctl #(.X_INIT(2)) dut2 (
        .i_pclk(clk), .i_rst(rst), .i_vblnk(vblnk),
        .i_left(left2), .i_right(zero), .i_jump(zero),
        .o_data(data2), .o_airborne(air2), .o_state(st2)
    );

    typedef struct {
        bit          chk;
        logic [19:0] d1;
        logic        a1;
        logic [19:0] d2;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic       upd_pending = 1'b0;
    logic       vb_prev     = 1'b0;
    logic       probe_req   = 1'b0;
    logic [9:0] x2_exp      = 10'd2;

    task automatic check_word(input string nm, input logic [19:0] act, input logic [19:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got y=%0d x=%0d, want y=%0d x=%0d",
                      nm, act[19:10], act[9:0], exp[19:10], exp[9:0]);
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", nm, act, exp);
    endtask

    // Independent view of when a frame update lands on the outputs.
    always @(posedge clk) begin
        upd_pending <= vblnk & ~vb_prev & ~rst;
        vb_prev     <= rst ? 1'b0 : vblnk;
    end

    always @(negedge clk) begin
        if (upd_pending || probe_req) begin
            exp_t e;
            probe_req = 1'b0;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL underflow: output update with empty expected queue, data=%h", data1);
            end else begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    check_word({e.name, ".data"}, data1, e.d1);
                    check_bit({e.name, ".air"}, air1, e.a1);
                    check_word({e.name, ".data2"}, data2, e.d2);
                    check_bit({e.name, ".air2"}, air2, 1'b0);
                end
            end
        end
    end

    task automatic frame(input logic l, input logic r, input logic j, input logic l2,
                         input bit chk, input logic [9:0] ey, input logic [9:0] ex,
                         input logic ea, input string nm);
        exp_t e;
        @(negedge clk);
        left = l; right = r; jump = j; left2 = l2;
        e = '{chk, {ey, ex}, ea, {10'd640, x2_exp}, nm};
        exp_q.push_back(e);
        vblnk = 1'b1;
        @(negedge clk);
        vblnk = 1'b0;
        @(negedge clk);
    endtask

    task automatic probe(input logic [9:0] ey, input logic [9:0] ex, input logic ea, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e = '{1'b1, {ey, ex}, ea, {10'd640, x2_exp}, nm};
        exp_q.push_back(e);
        probe_req = 1'b1;
        @(negedge clk);
    endtask

    // y at tick k of a jump started from the ground (k=0 is the launch tick).
    function automatic logic [9:0] jy(input int k);
        int m;
        if (k <= 0 || k >= 40) return 10'd640;
        if (k <= 20) return 10'(640 - (20 * k - (k * (k - 1)) / 2));
        m = k - 20;
        return 10'(430 + (m * (m + 1)) / 2);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        probe(10'd640, 10'd224, 1'b0, "reset");

        for (int k = 0; k < 3; k++) frame(0, 0, 0, 0, 1, 10'd640, 10'd224, 1'b0, "idle");

        x2_exp = 10'd0;
        for (int k = 0; k < 3; k++) frame(0, 0, 0, 1, 1, 10'd640, 10'd224, 1'b0, "left_clamp0");

        for (int k = 1; k <= 80; k++) begin
            int xe;
            xe = (224 + 4 * k > 512) ? 512 : 224 + 4 * k;
            frame(0, 1, 0, 0, 1, 10'd640, 10'(xe), 1'b0, "right_clamp");
        end
        frame(1, 0, 0, 0, 1, 10'd640, 10'd508, 1'b0, "left_step");
        frame(1, 1, 0, 0, 1, 10'd640, 10'd508, 1'b0, "both_hold");
        frame(0, 0, 0, 0, 1, 10'd640, 10'd508, 1'b0, "none_hold");

        // Jump pulse, then press jump exactly on the landing tick.
        frame(0, 0, 1, 0, 1, jy(0), 10'd508, 1'b1, "jump_launch");
        for (int k = 1; k < 40; k++) frame(0, 0, 0, 0, 1, jy(k), 10'd508, 1'b1, "jump_arc");
        frame(0, 0, 1, 0, 1, 10'd640, 10'd508, 1'b0, "land_only");

        // Still armed, so the held jump launches; holding it through the whole arc.
        for (int k = 0; k < 40; k++) frame(0, 0, 1, 0, 1, jy(k), 10'd508, 1'b1, "held_arc");
        frame(0, 0, 1, 0, 1, 10'd640, 10'd508, 1'b0, "held_land");
        frame(0, 0, 1, 0, 1, 10'd640, 10'd508, 1'b0, "no_repeat");
        frame(0, 0, 0, 0, 1, 10'd640, 10'd508, 1'b0, "rearm");
        frame(0, 0, 1, 0, 1, jy(0), 10'd508, 1'b1, "rejump");
        for (int k = 1; k < 10; k++) frame(0, 0, 0, 0, 1, jy(k), 10'd508, 1'b1, "rejump_arc");

        // Reset on what would be tick 10 of the jump.
        @(negedge clk);
        rst = 1'b1; vblnk = 1'b1; jump = 1'b0;
        x2_exp = 10'd2;
        probe(10'd640, 10'd224, 1'b0, "mid_jump_reset");
        rst = 1'b0; vblnk = 1'b0;

        // vblnk held high for many cycles gives a single update.
        @(negedge clk);
        @(negedge clk);
        right = 1'b1;
        begin
            exp_t e;
            e = '{1'b1, {10'd640, 10'd228}, 1'b0, {10'd640, 10'd2}, "long_vblnk"};
            exp_q.push_back(e);
        end
        vblnk = 1'b1;
        repeat (20) @(negedge clk);
        probe(10'd640, 10'd228, 1'b0, "long_vblnk_hold");
        vblnk = 1'b0;
        right = 1'b0;

        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries never matched by an output update, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
